mult_datapath: RTL and testbench
================================

Name: mult_datapath

Overview:
Arithmetic datapath for the sequential 8x8 multiplier; sits directly downstream of the multiplier controller and consumes its input_sel, shift_sel, clk_ena, sclr_n and done.
- Captures two 8-bit operands.
- Forms one 4x4 nibble partial product per enabled cycle, shifts it, and accumulates it into a 16-bit product.
- Generates the 2-bit count that the controller sequences on.

Parameters:
- OP_W, 8, operand width; the only supported value is 8 (nibble split fixed at 4).
- ACC_W, 16, accumulator/product width; equals 2*OP_W.

Ports:
- clk  input  1  clock, rising edge.
- reset_a  input  1  asynchronous, active-low reset.
- dataa  input  8  operand A, sampled on the clear cycle.
- datab  input  8  operand B, sampled on the clear cycle.
- input_sel  input  2  nibble-pair select from the controller.
- shift_sel  input  2  partial-product shift select from the controller.
- clk_ena  input  1  accumulate/count enable from the controller.
- sclr_n  input  1  synchronous clear, active-low, from the controller.
- done  input  1  calculation-complete strobe from the controller.
- count  output  2  partial-product index, fed back to the controller.
- product  output  16  accumulated product.
- result_valid  output  1  product holds a completed result.

Behaviour:
- Reset (reset_a=0, async): operand regs=0, acc=0, count=0, result_valid=0; with the optional feature, the result reg=0 as well.
- Clear cycle (sclr_n=0 at a clk edge, regardless of clk_ena):
  - acc<=0, count<=0, result_valid<=0.
  - a_reg<=dataa, b_reg<=datab.
  - sclr_n has priority over clk_ena.
- Accumulate (sclr_n=1, clk_ena=1):
  - acc<=acc+term; count<=count+1, wrapping 3 to 0.
- Hold (sclr_n=1, clk_ena=0): acc, count and operand regs unchanged.
- input_sel to nibble pair:
  - 00 = a[3:0]*b[3:0]
  - 01 = a[3:0]*b[7:4]
  - 10 = a[7:4]*b[3:0]
  - 11 = a[7:4]*b[7:4]
- The 4x4 product is 8 bits unsigned and is zero-extended to 16 bits before shifting.
- shift_sel to term:
  - 00 = pp<<0
  - 01 = pp<<4
  - 10 = pp<<8
  - 11 = reserved; term forced to 0, so acc still advances by 0 and count still increments.
- Addition is 16-bit modulo; no carry-out. A legal four-step sequence never exceeds 0xFE01.
- Latency: product is final one clk after the MSB step (the edge where count wraps 3 to 0); done is high in that same following cycle.
- done=1 at a clk edge: result_valid<=1. It stays 1 until the next clear cycle or reset.
- Simultaneous done=1 and sclr_n=0: clear wins, result_valid<=0.
- Reset mid-operation: everything returns to reset values immediately, with no partial result retained.
- Operand changes outside the clear cycle have no effect.
- product is combinationally equal to acc unless the optional feature is compiled in.

Optional Feature:
- Macro: MULT_RESULT_HOLD_EN.
- Defined:
  - A separate 16-bit result register loads acc on the done=1 edge.
  - product drives the result register, so it holds the last completed result through later clears and partial steps.
  - result_valid still drops on clear.
- Undefined: no result register; product=acc and shows partial sums during a calculation.

Decomposition:
- Package mult_pkg:
  - widths: OP_W=8, NIB_W=4, ACC_W=16
  - input_sel encodings: SEL_LL=2'b00, SEL_LH=2'b01, SEL_HL=2'b10, SEL_HH=2'b11
  - shift_sel encodings: SH_0=2'b00, SH_4=2'b01, SH_8=2'b10, SH_RSV=2'b11
  - count width CNT_W=2
- Sub-module mult4x4: combinational 4x4 unsigned multiplier (two 4-bit inputs, one 8-bit output), instantiated once.
- Nibble mux, shifter, accumulator, counter and result logic stay in mult_datapath.

Test Plan:
1. Max operands: dataa=0xFF, datab=0xFF.
   - Stimulus: clear, then steps (00,00), (01,01), (10,01), (11,10) with clk_ena=1, then done.
   - Expected: product=0xFE01, result_valid=1, count back to 0.
2. Mixed operands: dataa=0x12, datab=0x34, same sequence.
   - Expected acc after each step: 0x0008, 0x0068, 0x00A8, 0x03A8; final product=0x03A8.
3. Hold: clk_ena=0 for 3 cycles between steps 2 and 3 (sclr_n=1).
   - Expected: acc and count frozen; final product still correct.
4. Reserved shift: shift_sel=11 with clk_ena=1 after a clear.
   - Expected: acc stays 0x0000, count increments to 1.
5. Reset mid-operation: reset_a low after step 2.
   - Expected: product=0, count=0, result_valid=0 asynchronously; a fresh 0x03*0x05 run gives 0x000F.
6. Optional feature: with MULT_RESULT_HOLD_EN defined, complete 0x12*0x34, then clear and step with 0xFF*0xFF.
   - Expected: product stays 0x03A8 until the new done, then 0xFE01.
   - Without the macro, product shows the partial sums.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared widths and control encodings for the sequential 8x8 multiplier datapath.
package mult_pkg;
    localparam int OP_W  = 8;
    localparam int NIB_W = 4;
    localparam int ACC_W = 16;
    localparam int CNT_W = 2;

    localparam logic [1:0] SEL_LL = 2'b00;
    localparam logic [1:0] SEL_LH = 2'b01;
    localparam logic [1:0] SEL_HL = 2'b10;
    localparam logic [1:0] SEL_HH = 2'b11;

    localparam logic [1:0] SH_0   = 2'b00;
    localparam logic [1:0] SH_4   = 2'b01;
    localparam logic [1:0] SH_8   = 2'b10;
    localparam logic [1:0] SH_RSV = 2'b11;

    // Zero-extend the nibble product and place it; the reserved code yields no contribution.
    function automatic logic [ACC_W-1:0] shift_pp(input logic [2*NIB_W-1:0] pp,
                                                  input logic [1:0]         sh);
        logic [ACC_W-1:0] ext;
        ext = {{(ACC_W-2*NIB_W){1'b0}}, pp};
        case (sh)
            SH_0:    shift_pp = ext;
            SH_4:    shift_pp = ext << NIB_W;
            SH_8:    shift_pp = ext << (2*NIB_W);
            SH_RSV:  shift_pp = '0;
            default: shift_pp = '0;
        endcase
    endfunction
endpackage

// File: rtl/mult4x4.sv
// Combinational 4x4 unsigned multiplier used for one nibble partial product per step.
module mult4x4
    import mult_pkg::*;
(
    input  logic [NIB_W-1:0]   a_i,
    input  logic [NIB_W-1:0]   b_i,
    output logic [2*NIB_W-1:0] p_o
);

    assign p_o = {{NIB_W{1'b0}}, a_i} * {{NIB_W{1'b0}}, b_i};

endmodule

// File: rtl/mult_datapath.sv
// Datapath of the sequential 8x8 multiplier: operand capture, nibble mux, shift/accumulate, step count.
// Optional MULT_RESULT_HOLD_EN adds a result register so product keeps the last completed result.
module mult_datapath
    import mult_pkg::*;
#(
    parameter int OP_W  = mult_pkg::OP_W,
    parameter int ACC_W = mult_pkg::ACC_W
) (
    input  logic              clk,
    input  logic              reset_a,
    input  logic [OP_W-1:0]   dataa,
    input  logic [OP_W-1:0]   datab,
    input  logic [1:0]        input_sel,
    input  logic [1:0]        shift_sel,
    input  logic              clk_ena,
    input  logic              sclr_n,
    input  logic              done,
    output logic [CNT_W-1:0]  count,
    output logic [ACC_W-1:0]  product,
    output logic              result_valid
);

    logic [OP_W-1:0]    a_q, a_d;
    logic [OP_W-1:0]    b_q, b_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rv_q, rv_d;

    logic [NIB_W-1:0]   nib_a, nib_b;
    logic [2*NIB_W-1:0] pp;
    logic [ACC_W-1:0]   term;

    // input_sel[1] picks the A nibble, input_sel[0] the B nibble.
    always_comb begin
        nib_a = a_q[NIB_W-1:0];
        nib_b = b_q[NIB_W-1:0];
        case (input_sel)
            SEL_LL: begin nib_a = a_q[NIB_W-1:0];    nib_b = b_q[NIB_W-1:0];    end
            SEL_LH: begin nib_a = a_q[NIB_W-1:0];    nib_b = b_q[OP_W-1:NIB_W]; end
            SEL_HL: begin nib_a = a_q[OP_W-1:NIB_W]; nib_b = b_q[NIB_W-1:0];    end
            SEL_HH: begin nib_a = a_q[OP_W-1:NIB_W]; nib_b = b_q[OP_W-1:NIB_W]; end
            default: ;
        endcase
    end

    mult4x4 u_mult4x4 (
        .a_i (nib_a),
        .b_i (nib_b),
        .p_o (pp)
    );

    assign term = shift_pp(pp, shift_sel);

    // Clear outranks accumulate, and clear outranks done for result_valid.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        rv_d  = rv_q;
        if (!sclr_n) begin
            a_d   = dataa;
            b_d   = datab;
            acc_d = '0;
            cnt_d = '0;
            rv_d  = 1'b0;
        end else begin
            if (clk_ena) begin
                acc_d = acc_q + term;
                cnt_d = cnt_q + 1'b1;
            end
            if (done) rv_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            rv_q  <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            rv_q  <= rv_d;
        end
    end

`ifdef MULT_RESULT_HOLD_EN
    logic [ACC_W-1:0] res_q, res_d;

    always_comb begin
        res_d = res_q;
        if (done) res_d = acc_q;
    end

    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) res_q <= '0;
        else          res_q <= res_d;
    end

    assign product = res_q;
`else
    assign product = acc_q;
`endif

    assign count        = cnt_q;
    assign result_valid = rv_q;

endmodule

// File: tb/tb_mult_datapath.sv
// Randomized scoreboard bench for mult_datapath against an arithmetic reference model.
module tb_mult_datapath;

    logic        clk = 1'b0;
    logic        reset_a;
    logic [7:0]  dataa, datab;
    logic [1:0]  input_sel, shift_sel;
    logic        clk_ena, sclr_n, done;
    logic [1:0]  count;
    logic [15:0] product;
    logic        result_valid;

    mult_datapath dut (
        .clk          (clk),
        .reset_a      (reset_a),
        .dataa        (dataa),
        .datab        (datab),
        .input_sel    (input_sel),
        .shift_sel    (shift_sel),
        .clk_ena      (clk_ena),
        .sclr_n       (sclr_n),
        .done         (done),
        .count        (count),
        .product      (product),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] prod;
        logic [1:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference state: operands, running sum, step count, last completed result.
    int unsigned a_m, b_m, acc_m, cnt_m, last_res;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic int unsigned model_term(input int unsigned a, input int unsigned b,
                                               input int unsigned isel, input int unsigned ssel);
        int unsigned na, nb;
        if (ssel == 3) return 0;
        na = (a / (isel >= 2 ? 16 : 1)) % 16;
        nb = (b / (isel % 2 == 1 ? 16 : 1)) % 16;
        return (na * nb * (16 ** ssel)) % 65536;
    endfunction

    function automatic logic [15:0] visible();
`ifdef MULT_RESULT_HOLD_EN
        return 16'(last_res);
`else
        return 16'(acc_m);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear(input logic [7:0] a, input logic [7:0] b);
        dataa   = a;
        datab   = b;
        sclr_n  = 1'b0;
        clk_ena = 1'($urandom_range(0, 1));
        done    = 1'b0;
        input_sel = 2'($urandom);
        shift_sel = 2'($urandom);
        tick();
        sclr_n  = 1'b1;
        clk_ena = 1'b0;
        a_m = a; b_m = b; acc_m = 0; cnt_m = 0;
        chk("clear_count", 16'(count), 16'd0);
        chk("clear_valid", 16'(result_valid), 16'd0);
        chk("clear_product", product, visible());
    endtask

    task automatic do_step(input logic [1:0] isel, input logic [1:0] ssel);
        input_sel = isel;
        shift_sel = ssel;
        clk_ena   = 1'b1;
        tick();
        clk_ena   = 1'b0;
        acc_m = (acc_m + model_term(a_m, b_m, isel, ssel)) % 65536;
        cnt_m = (cnt_m + 1) % 4;
        chk("step_product", product, visible());
        chk("step_count", 16'(count), 16'(cnt_m));
    endtask

    task automatic do_hold(input int n);
        for (int i = 0; i < n; i++) begin
            dataa = 8'($urandom);
            datab = 8'($urandom);
            input_sel = 2'($urandom);
            shift_sel = 2'($urandom);
            tick();
        end
        chk("hold_product", product, visible());
        chk("hold_count", 16'(count), 16'(cnt_m));
    endtask

    task automatic do_done();
        exp_t e;
        done = 1'b1;
        e.prod = 16'(acc_m);
        e.cnt  = 2'(cnt_m);
        exp_q.push_back(e);
        tick();
        done = 1'b0;
        last_res = acc_m;
    endtask

    task automatic legal_run(input logic [7:0] a, input logic [7:0] b, input bit holds);
        do_clear(a, b);
        do_step(2'b00, 2'b00);
        do_step(2'b01, 2'b01);
        if (holds) do_hold(3);
        do_step(2'b10, 2'b01);
        do_step(2'b11, 2'b10);
        do_done();
    endtask

    // Monitor: each new assertion of result_valid retires one expected result.
    logic rv_prev = 1'b0;
    always @(negedge clk) begin
        if (result_valid && !rv_prev) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: got %h want none", product);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result_product", product, e.prod);
                chk("result_count", 16'(count), 16'(e.cnt));
            end
        end
        rv_prev <= result_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_a = 1'b0;
        dataa = '0; datab = '0; input_sel = '0; shift_sel = '0;
        clk_ena = 1'b0; sclr_n = 1'b1; done = 1'b0;
        a_m = 0; b_m = 0; acc_m = 0; cnt_m = 0; last_res = 0;
        #2;
        chk("reset_product", product, 16'h0000);
        chk("reset_count", 16'(count), 16'd0);
        chk("reset_valid", 16'(result_valid), 16'd0);
        tick();
        reset_a = 1'b1;
        tick();

        legal_run(8'hFF, 8'hFF, 1'b0);
        chk("max_product", product, 16'hFE01);
        chk("max_valid", 16'(result_valid), 16'd1);
        chk("max_count", 16'(count), 16'd0);

        legal_run(8'h12, 8'h34, 1'b1);
        chk("mixed_product", product, 16'h03A8);

        // Clear and done on the same edge: clear wins.
        sclr_n = 1'b0;
        done   = 1'b1;
        tick();
        sclr_n = 1'b1;
        done   = 1'b0;
        last_res = acc_m;
        acc_m = 0; cnt_m = 0;
        chk("clr_done_valid", 16'(result_valid), 16'd0);
        chk("clr_done_product", product, visible());

        // Reserved shift still counts but adds nothing.
        do_clear(8'hA5, 8'h5A);
        do_step(2'b11, 2'b11);
        chk("rsv_acc", 16'(acc_m), 16'h0000);
        chk("rsv_count", 16'(count), 16'd1);

        // Asynchronous reset part-way through a calculation.
        do_clear(8'h12, 8'h34);
        do_step(2'b00, 2'b00);
        do_step(2'b01, 2'b01);
        #2;
        reset_a = 1'b0;
        #1;
        acc_m = 0; cnt_m = 0; last_res = 0;
        chk("midrst_product", product, 16'h0000);
        chk("midrst_count", 16'(count), 16'd0);
        chk("midrst_valid", 16'(result_valid), 16'd0);
        tick();
        reset_a = 1'b1;
        legal_run(8'h03, 8'h05, 1'b0);
        chk("fresh_product", product, 16'h000F);

        for (int t = 0; t < 40; t++) begin
            do_clear(8'($urandom), 8'($urandom));
            for (int s = 0; s < 4; s++) begin
                if ($urandom_range(0, 1) == 1) begin
                    do_step(2'(s), (s == 0) ? 2'b00 : (s == 3) ? 2'b10 : 2'b01);
                end else begin
                    do_step(2'($urandom), 2'($urandom));
                end
                if ($urandom_range(0, 3) == 0) do_hold($urandom_range(1, 2));
            end
            if ($urandom_range(0, 4) == 0) do_step(2'($urandom), 2'($urandom));
            do_done();
        end

        tick();
        tick();
        chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
